// File: rtl/clint_mh.sv
// Core-local interruptor: shared 64-bit mtime with prescaler, per-hart mtimecmp and msip,
// registered interrupt lines and a one-cycle-latency memory-mapped register port.
module clint_mh #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          NHARTS    = 2,
    parameter int          TICK_DIV  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wen,
    input  logic              i_ren,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wrdata,
    output logic [31:0]       o_rddata,
    output logic              o_rdvalid,
    output logic              o_err,
    output logic [NHARTS-1:0] o_msip,
    output logic [NHARTS-1:0] o_mtip
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [31:0]      MSIP_END = 32'(4 * NHARTS);
    localparam logic [31:0]      CMP_BASE = 32'h0000_4000;
    localparam logic [31:0]      CMP_END  = CMP_BASE + 32'(8 * NHARTS);

    logic [63:0]       mtime_q, mtime_d;
    logic [CNT_W-1:0]  pre_q, pre_d;
    logic [NHARTS-1:0] msip_q, msip_d;
    logic [63:0]       cmp_q [NHARTS];
    logic [63:0]       cmp_d [NHARTS];
    logic [31:0]       rddata_q, rddata_d;
    logic              rdvalid_q, err_q;
    logic [NHARTS-1:0] mtip_q, mtip_d, msip_out_q;

    logic [31:0] offset;
    logic        in_win, aligned, sel_msip, sel_cmp, sel_mtime, sel_hi, mapped, tick;
    logic [3:0]  msip_idx, cmp_idx;

    assign offset    = i_addr - BASE_ADDR;
    assign in_win    = (i_addr >= BASE_ADDR) && (offset < 32'h0000_C000);
    assign aligned   = (i_addr[1:0] == 2'b00);
    assign sel_msip  = in_win && aligned && (offset < MSIP_END);
    assign sel_cmp   = in_win && aligned && (offset >= CMP_BASE) && (offset < CMP_END);
    // 0xBFF8 and 0xBFFC share everything above bit 2
    assign sel_mtime = in_win && aligned && (offset[31:3] == 29'h0000_17FF);
    assign sel_hi    = offset[2];
    assign mapped    = sel_msip || sel_cmp || sel_mtime;
    assign msip_idx  = offset[5:2];
    assign cmp_idx   = offset[6:3];
    assign tick      = (pre_q == CNT_MAX);

    always_comb begin
        pre_d    = tick ? '0 : pre_q + CNT_W'(1);
        mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
        msip_d   = msip_q;
        cmp_d    = cmp_q;
        rddata_d = '0;
        mtip_d   = '0;
        // A bus write to mtime beats the tick and restarts the prescaler
        if (i_wen && sel_mtime) begin
            pre_d = '0;
            if (sel_hi) mtime_d = {i_wrdata, mtime_q[31:0]};
            else        mtime_d = {mtime_q[63:32], i_wrdata};
        end
        if (sel_mtime) rddata_d = sel_hi ? mtime_q[63:32] : mtime_q[31:0];
        for (int h = 0; h < NHARTS; h++) begin
            if (i_wen && sel_msip && (msip_idx == 4'(h))) msip_d[h] = i_wrdata[0];
            if (i_wen && sel_cmp && (cmp_idx == 4'(h))) begin
                if (sel_hi) cmp_d[h][63:32] = i_wrdata;
                else        cmp_d[h][31:0]  = i_wrdata;
            end
            if (sel_msip && (msip_idx == 4'(h))) rddata_d = {31'b0, msip_q[h]};
            if (sel_cmp && (cmp_idx == 4'(h)))
                rddata_d = sel_hi ? cmp_q[h][63:32] : cmp_q[h][31:0];
            mtip_d[h] = (mtime_q >= cmp_q[h]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mtime_q    <= '0;
            pre_q      <= '0;
            msip_q     <= '0;
            for (int h = 0; h < NHARTS; h++) cmp_q[h] <= '1;
            rddata_q   <= '0;
            rdvalid_q  <= 1'b0;
            err_q      <= 1'b0;
            mtip_q     <= '0;
            msip_out_q <= '0;
        end else begin
            mtime_q    <= mtime_d;
            pre_q      <= pre_d;
            msip_q     <= msip_d;
            for (int h = 0; h < NHARTS; h++) cmp_q[h] <= cmp_d[h];
            if (i_ren) rddata_q <= rddata_d;
            rdvalid_q  <= i_ren;
            err_q      <= (i_ren || i_wen) && !mapped;
            mtip_q     <= mtip_d;
            msip_out_q <= msip_q;
        end
    end

    assign o_rddata  = rddata_q;
    assign o_rdvalid = rdvalid_q;
    assign o_err     = err_q;
    assign o_msip    = msip_out_q;
    assign o_mtip    = mtip_q;

endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: a TICK_DIV=1 instance and a TICK_DIV=4 instance share one bus;
// a vector table covers register access, hand sequences cover timing corners.
module tb_clint_mh;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        i_clk, i_rst, i_wen, i_ren;
    logic [31:0] i_addr, i_wrdata;
    logic [31:0] o_rddata, o_rddata4;
    logic        o_rdvalid, o_rdvalid4, o_err, o_err4;
    logic [1:0]  o_msip, o_msip4, o_mtip, o_mtip4;

    int total = 0;
    int bad   = 0;

    clint_mh #(.BASE_ADDR(BASE), .NHARTS(2), .TICK_DIV(1)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wen(i_wen), .i_ren(i_ren),
        .i_addr(i_addr), .i_wrdata(i_wrdata), .o_rddata(o_rddata),
        .o_rdvalid(o_rdvalid), .o_err(o_err), .o_msip(o_msip), .o_mtip(o_mtip)
    );

    clint_mh #(.BASE_ADDR(BASE), .NHARTS(2), .TICK_DIV(4)) u_dut4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_wen(i_wen), .i_ren(i_ren),
        .i_addr(i_addr), .i_wrdata(i_wrdata), .o_rddata(o_rddata4),
        .o_rdvalid(o_rdvalid4), .o_err(o_err4), .o_msip(o_msip4), .o_mtip(o_mtip4)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [15:0] off;
        logic [31:0] wdata;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_msip;
    } vec_t;

    vec_t vecs [18];

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] off, input logic [31:0] d);
        i_addr   = BASE + {16'h0, off};
        i_wrdata = d;
        i_wen    = 1'b1;
        cyc();
        i_wen    = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] off);
        i_addr = BASE + {16'h0, off};
        i_ren  = 1'b1;
        cyc();
        i_ren  = 1'b0;
    endtask

    initial begin
        i_rst = 1'b0; i_wen = 1'b0; i_ren = 1'b0; i_addr = '0; i_wrdata = '0;

        vecs[0]  = '{1'b0, 1'b1, 16'h4000, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 2'b00};
        vecs[1]  = '{1'b0, 1'b1, 16'h4004, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 2'b00};
        vecs[2]  = '{1'b0, 1'b1, 16'h400C, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 2'b00};
        vecs[3]  = '{1'b0, 1'b1, 16'h0000, 32'h0,         1'b1, 1'b0, 32'h0,         2'b00};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         2'b00};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 32'h0,         1'b1, 1'b0, 32'h1,         2'b01};
        vecs[6]  = '{1'b0, 1'b1, 16'h0008, 32'h0,         1'b1, 1'b1, 32'h0,         2'b01};
        vecs[7]  = '{1'b0, 1'b1, 16'h4001, 32'h0,         1'b1, 1'b1, 32'h0,         2'b01};
        vecs[8]  = '{1'b1, 1'b0, 16'h4010, 32'hAAAA_5555, 1'b0, 1'b1, 32'h0,         2'b01};
        vecs[9]  = '{1'b1, 1'b0, 16'h4008, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         2'b01};
        vecs[10] = '{1'b0, 1'b1, 16'h4008, 32'h0,         1'b1, 1'b0, 32'h1234_5678, 2'b01};
        vecs[11] = '{1'b0, 1'b1, 16'h400C, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 2'b01};
        vecs[12] = '{1'b1, 1'b0, 16'h0004, 32'h0000_0002, 1'b0, 1'b0, 32'h0,         2'b01};
        vecs[13] = '{1'b0, 1'b1, 16'h0004, 32'h0,         1'b1, 1'b0, 32'h0,         2'b01};
        vecs[14] = '{1'b0, 1'b1, 16'hC000, 32'h0,         1'b1, 1'b1, 32'h0,         2'b01};
        vecs[15] = '{1'b0, 1'b1, 16'h4010, 32'h0,         1'b1, 1'b1, 32'h0,         2'b01};
        vecs[16] = '{1'b1, 1'b0, 16'h4008, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         2'b01};
        vecs[17] = '{1'b1, 1'b0, 16'h0000, 32'h0,         1'b0, 1'b0, 32'h0,         2'b01};

        // reset held for two edges
        repeat (2) cyc();
        check("rst mtip", 64'(o_mtip), 64'h0);
        check("rst msip", 64'(o_msip), 64'h0);
        check("rst rdvalid", 64'(o_rdvalid), 64'h0);
        check("rst err", 64'(o_err), 64'h0);
        check("rst rddata", 64'(o_rddata), 64'h0);
        i_rst = 1'b1;

        // prescaler: 40 edges after reset, then sample mtime low
        repeat (40) cyc();
        bus_rd(16'hBFF8);
        check("presc div1", 64'(o_rddata), 64'd40);
        check("presc div4", 64'(o_rddata4), 64'd10);
        check("presc rdvalid", 64'(o_rdvalid), 64'h1);
        cyc();
        check("rdvalid drop", 64'(o_rdvalid), 64'h0);
        check("rddata hold", 64'(o_rddata), 64'd40);

        // register access table, one vector per cycle
        for (int i = 0; i < 18; i++) begin
            i_addr   = BASE + {16'h0, vecs[i].off};
            i_wrdata = vecs[i].wdata;
            i_wen    = vecs[i].wen;
            i_ren    = vecs[i].ren;
            cyc();
            i_wen = 1'b0;
            i_ren = 1'b0;
            check($sformatf("v%0d rdvalid", i), 64'(o_rdvalid), 64'(vecs[i].exp_valid));
            check($sformatf("v%0d err", i), 64'(o_err), 64'(vecs[i].exp_err));
            if (vecs[i].exp_valid)
                check($sformatf("v%0d rddata", i), 64'(o_rddata), 64'(vecs[i].exp_rdata));
            check($sformatf("v%0d msip", i), 64'(o_msip), 64'(vecs[i].exp_msip));
            check($sformatf("v%0d mtip", i), 64'(o_mtip), 64'h0);
        end
        cyc();
        check("msip clear", 64'(o_msip), 64'h0);

        // timer interrupt on hart 1 at mtime == 100
        bus_wr(16'hBFF8, 32'h0);
        bus_wr(16'h400C, 32'h0);
        bus_wr(16'h4008, 32'd100);
        bus_wr(16'hBFF8, 32'd90);
        repeat (10) cyc();
        check("mtip before 100", 64'(o_mtip), 64'h0);
        cyc();
        check("mtip at 100", 64'(o_mtip), 64'b10);
        bus_wr(16'h4008, 32'hFFFF_FFFF);
        check("mtip lag", 64'(o_mtip), 64'b10);
        cyc();
        check("mtip fall", 64'(o_mtip), 64'h0);
        bus_wr(16'h400C, 32'hFFFF_FFFF);

        // 64-bit rollover against all-ones compare values
        bus_wr(16'hBFFC, 32'hFFFF_FFFF);
        bus_wr(16'hBFF8, 32'hFFFF_FFFE);
        cyc();
        check("roll mtip pre", 64'(o_mtip), 64'h0);
        cyc();
        check("roll mtip max", 64'(o_mtip), 64'b11);
        cyc();
        check("roll mtip wrap", 64'(o_mtip), 64'h0);
        bus_rd(16'hBFF8);
        check("roll lo", 64'(o_rddata), 64'd1);
        bus_rd(16'hBFFC);
        check("roll hi", 64'(o_rddata), 64'd0);

        // mtime write beats tick and restarts prescaler; back-to-back reads
        bus_wr(16'hBFF8, 32'h55);
        i_addr = BASE + 32'hBFF8;
        i_ren  = 1'b1;
        cyc();
        check("wprio div1 r0", 64'(o_rddata), 64'h55);
        check("wprio div4 r0", 64'(o_rddata4), 64'h55);
        cyc();
        check("b2b rdvalid", 64'(o_rdvalid), 64'h1);
        check("wprio div1 r1", 64'(o_rddata), 64'h56);
        check("wprio div4 r1", 64'(o_rddata4), 64'h55);
        i_ren = 1'b0;
        cyc();
        check("b2b rdvalid end", 64'(o_rdvalid), 64'h0);
        i_ren = 1'b1;
        cyc();
        check("wprio div1 r2", 64'(o_rddata), 64'h58);
        check("wprio div4 r2", 64'(o_rddata4), 64'h55);
        cyc();
        check("wprio div1 r3", 64'(o_rddata), 64'h59);
        check("wprio div4 r3", 64'(o_rddata4), 64'h56);
        i_ren = 1'b0;

        // simultaneous write and read of MSIP[1]
        i_addr   = BASE + 32'h0004;
        i_wrdata = 32'h1;
        i_wen    = 1'b1;
        i_ren    = 1'b1;
        cyc();
        i_wen = 1'b0;
        check("rw old value", 64'(o_rddata), 64'h0);
        check("rw rdvalid", 64'(o_rdvalid), 64'h1);
        cyc();
        i_ren = 1'b0;
        check("rw new value", 64'(o_rddata), 64'h1);
        check("rw msip1", 64'(o_msip), 64'b10);
        bus_wr(16'h0004, 32'h0);

        // reset during a write discards the write
        i_rst    = 1'b0;
        i_addr   = BASE;
        i_wrdata = 32'h1;
        i_wen    = 1'b1;
        cyc();
        i_wen = 1'b0;
        i_rst = 1'b1;
        check("midrst rdvalid", 64'(o_rdvalid), 64'h0);
        check("midrst mtip", 64'(o_mtip), 64'h0);
        bus_rd(16'h0000);
        check("midrst msip0 rd", 64'(o_rddata), 64'h0);
        bus_rd(16'h4000);
        check("midrst cmp rd", 64'(o_rddata), 64'hFFFF_FFFF);
        cyc();
        check("midrst msip out", 64'(o_msip), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
